div_ctrl: RTL and testbench
===========================

# div_ctrl

Sequencing controller for the 32-bit multi-cycle divider in the execute stage. It accepts DIV/DIVU/REM/REMU instructions from EX and handles the cases that need no division. For the rest it issues a request to the divider, stalls the pipeline, and drives the register-file write port with the result. It also discards results orphaned by a flush and flags a divider that never answers.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles in WAIT before the controller gives up.

Ports (clock and reset first; one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ex_div_req_i  in  1  EX holds a div-class instruction
- ex_div_op_i  in  3  DIV/DIVU/REM/REMU encoding from defines.v
- ex_data1_i  in  32  dividend
- ex_data2_i  in  32  divisor
- ex_rd_i  in  5  destination register
- flush_i  in  1  pipeline flush (jump or interrupt)
- hold_o  out  1  pipeline stall, combinational
- div_req_o  out  1  request to divider, combinational
- div_op_code_o  out  3  latched op
- div_data1_o  out  32  latched dividend
- div_data2_o  out  32  latched divisor
- div_reg_wr_addr_o  out  5  latched rd
- div_busy_i  in  1  divider busy
- div_res_ready_i  in  1  divider result pulse
- div_res_i  in  32  divider result
- wb_we_o  out  1  register-file write enable, registered
- wb_addr_o  out  5  write address, registered
- wb_data_o  out  32  write data, registered
- div_err_o  out  1  sticky timeout flag
- div_stall_cnt_o  out  32  count of hold_o cycles, wraps

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- IDLE, with ex_div_req_i & ~flush_i:
  - rd==0: instruction is dropped; no hold, no divider request.
  - divisor==0: fast result is registered, then go to WB. DIV/DIVU give 32'hFFFFFFFF; REM/REMU give the dividend. The divider is never requested.
  - otherwise: latch op, operands and rd, then go to ISSUE.
- ISSUE: div_req_o = ~div_busy_i; go to WAIT when it fires. If flush_i, go to IDLE with nothing issued.
- WAIT: on div_res_ready_i, capture div_res_i and go to WB.
  - flush_i: go to DRAIN.
  - timeout counter reaches TIMEOUT: go to WB with result 32'h0 and set div_err_o.
- WB: wb_we_o=1 for exactly one cycle with latched rd and result, then go to IDLE. ex_div_req_i is ignored in WB. If flush_i is high in the WB cycle, the write is suppressed.
- DRAIN: wait for div_res_ready_i, discard the result, then go to IDLE. flush_i has no further effect.
- hold_o = (IDLE & ex_div_req_i & ~flush_i & rd≠0) | ISSUE | WAIT | (DRAIN & ex_div_req_i).
- div_stall_cnt_o increments on every cycle with hold_o=1.
- The latched rd is used for writeback; div_reg_wr_addr_i from the divider is not used.

## Timing
- Reset values:
  - state = IDLE
  - wb_we_o = 0, wb_addr_o = 0, wb_data_o = 0
  - div_err_o = 0, div_stall_cnt_o = 0
  - latched operands, op and rd = 0
  - timeout counter = 0
- Reset mid-operation returns the controller to IDLE immediately. The divider is reset by the same rst.
- Normal path, with accept at cycle 0:
  - ISSUE at cycle 1, where div_req_o is high for one cycle.
  - WAIT from cycle 2.
  - WB in the cycle after div_res_ready_i.
  - hold_o falls in WB, so the pipeline advances at the end of WB.
- Fast path: WB at cycle 1; hold_o is high only in cycle 0.
- Timeout counter: cleared on entry to WAIT, increments each WAIT cycle, and fires when count == TIMEOUT-1.
- div_err_o stays high until reset.
- Simultaneous flush_i and div_res_ready_i in WAIT: the result is discarded and the state goes directly to IDLE.

## Structure
- defines.v: DIV/DIVU/REM/REMU encodings (already present), plus new constants for the state encoding and the default TIMEOUT.
- No sub-module is needed. The fast-path result logic is an always block inside div_ctrl.
- Top level: the divider sits beside div_ctrl. wb_* is ORed into the EX write port, and EX suppresses its own write for div opcodes.

## Test plan
- DIV -7/2 with rd=5 -> hold for the full sequence; one WB cycle writes x5 = 32'hFFFFFFFD; div_req_o pulses once.
- REM -7/2 and REMU 7/2 -> x5 = 32'hFFFFFFFF and 32'h1 respectively; back-to-back instructions are each accepted in IDLE.
- DIVU 9/0 and REM 5/0 -> WB at cycle 1 writing 32'hFFFFFFFF and 32'h5; div_req_o never asserted.
- DIV with rd=0 -> hold_o=0, no div_req_o, no wb_we_o.
- flush_i in WAIT, then a new DIV 10/3 presented -> DRAIN; the old result is not written; hold is held until the old div_res_ready_i; then 3 is written.
- div_res_ready_i tied low -> after 64 WAIT cycles, WB writes 0 and div_err_o=1 until rst; div_stall_cnt_o matches the counted hold cycles.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the divider sequencing controller.
// Op encodings, state encoding and default timeout.
package div_ctrl_pkg;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle divider in EX.
// Handles trivial cases, stalls, writeback, flush drain, timeout.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic [2:0]  ex_div_op_i,
  input  logic [31:0] ex_data1_i,
  input  logic [31:0] ex_data2_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        flush_i,
  output logic        hold_o,
  output logic        div_req_o,
  output logic [2:0]  div_op_code_o,
  output logic [31:0] div_data1_o,
  output logic [31:0] div_data2_o,
  output logic [4:0]  div_reg_wr_addr_o,
  input  logic        div_busy_i,
  input  logic        div_res_ready_i,
  input  logic [31:0] div_res_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        div_err_o,
  output logic [31:0] div_stall_cnt_o
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_e        state_q, state_d;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [4:0]    rd_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          wb_we_q;
  logic [4:0]    wb_addr_q, wb_addr_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          err_q;
  logic [31:0]   stall_q;

  logic          accept;
  logic          latch_en;
  logic          wb_set;
  logic          err_set;
  logic          hold;
  logic          req;
  logic          is_div;
  logic [31:0]   fast_res;

  assign accept = ex_div_req_i & ~flush_i
                & (ex_rd_i != 5'd0);

  // Result for a zero divisor: all-ones quotient or the dividend
  always_comb begin
    is_div   = (ex_div_op_i == OP_DIV)
             | (ex_div_op_i == OP_DIVU);
    fast_res = is_div ? 32'hFFFF_FFFF : ex_data1_i;
  end

  // Next state, stall, divider request and writeback staging
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    hold      = 1'b0;
    req       = 1'b0;
    latch_en  = 1'b0;
    wb_set    = 1'b0;
    wb_addr_d = 5'd0;
    wb_data_d = 32'd0;
    err_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          hold     = 1'b1;
          latch_en = 1'b1;
          if (ex_data2_i == 32'd0) begin
            state_d   = S_WB;
            wb_set    = 1'b1;
            wb_addr_d = ex_rd_i;
            wb_data_d = fast_res;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        hold = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!div_busy_i) begin
          req     = 1'b1;
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        hold   = 1'b1;
        tcnt_d = tcnt_q + 1'b1;
        if (flush_i) begin
          state_d = div_res_ready_i ? S_IDLE : S_DRAIN;
        end else if (div_res_ready_i) begin
          state_d   = S_WB;
          wb_set    = 1'b1;
          wb_addr_d = rd_q;
          wb_data_d = div_res_i;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d   = S_WB;
          wb_set    = 1'b1;
          wb_addr_d = rd_q;
          err_set   = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        hold = ex_div_req_i;
        if (div_res_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state, timeout counter and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_q | err_set;
    end
  end

  // Operands, op and rd captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      rd_q <= 5'd0;
    end else if (latch_en) begin
      op_q <= ex_div_op_i;
      a_q  <= ex_data1_i;
      b_q  <= ex_data2_i;
      rd_q <= ex_rd_i;
    end
  end

  // Writeback registers are nonzero only during WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      wb_we_q   <= wb_set;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Count every stalled cycle, wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 32'd0;
    end else if (hold) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign hold_o            = hold;
  assign div_req_o         = req;
  assign div_op_code_o     = op_q;
  assign div_data1_o       = a_q;
  assign div_data2_o       = b_q;
  assign div_reg_wr_addr_o = rd_q;
  // A flush landing in the WB cycle kills the write
  assign wb_we_o           = wb_we_q & ~flush_i;
  assign wb_addr_o         = wb_addr_q;
  assign wb_data_o         = wb_data_q;
  assign div_err_o         = err_q;
  assign div_stall_cnt_o   = stall_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl.
// The bench plays the divider and the EX stage.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_req_i;
  logic [2:0]  ex_div_op_i;
  logic [31:0] ex_data1_i;
  logic [31:0] ex_data2_i;
  logic [4:0]  ex_rd_i;
  logic        flush_i;
  logic        hold_o;
  logic        div_req_o;
  logic [2:0]  div_op_code_o;
  logic [31:0] div_data1_o;
  logic [31:0] div_data2_o;
  logic [4:0]  div_reg_wr_addr_o;
  logic        div_busy_i;
  logic        div_res_ready_i;
  logic [31:0] div_res_i;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        div_err_o;
  logic [31:0] div_stall_cnt_o;

  int checks = 0;
  int errors = 0;
  int n_hold = 0;
  int n_req  = 0;
  int n_wb   = 0;

  div_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(ex_div_req_i), .ex_div_op_i(ex_div_op_i),
    .ex_data1_i(ex_data1_i), .ex_data2_i(ex_data2_i),
    .ex_rd_i(ex_rd_i), .flush_i(flush_i),
    .hold_o(hold_o), .div_req_o(div_req_o),
    .div_op_code_o(div_op_code_o), .div_data1_o(div_data1_o),
    .div_data2_o(div_data2_o),
    .div_reg_wr_addr_o(div_reg_wr_addr_o),
    .div_busy_i(div_busy_i), .div_res_ready_i(div_res_ready_i),
    .div_res_i(div_res_i), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .div_err_o(div_err_o), .div_stall_cnt_o(div_stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_o)    n_hold++;
      if (div_req_o) n_req++;
      if (wb_we_o)   n_wb++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    ex_div_req_i = 1'b1;
    ex_div_op_i  = op;
    ex_data1_i   = a;
    ex_data2_i   = b;
    ex_rd_i      = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ex_div_req_i = 1'b0; ex_div_op_i = 3'd0;
    ex_data1_i = 32'd0; ex_data2_i = 32'd0; ex_rd_i = 5'd0;
    flush_i = 1'b0; div_busy_i = 1'b0;
    div_res_ready_i = 1'b0; div_res_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    do_reset();
    checks++;
    if (wb_we_o !== 1'b0 || wb_addr_o !== 5'd0 || wb_data_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_wb got we=%0b addr=%0d data=%h exp 0", wb_we_o, wb_addr_o, wb_data_o);
    end
    checks++;
    if (div_err_o !== 1'b0 || div_stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_err got err=%0b cnt=%0d exp 0", div_err_o, div_stall_cnt_o);
    end
    checks++;
    if (div_data1_o !== 32'd0 || div_data2_o !== 32'd0 ||
        div_op_code_o !== 3'd0 || div_reg_wr_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_latch got a=%h b=%h op=%0d rd=%0d exp 0",
               div_data1_o, div_data2_o, div_op_code_o, div_reg_wr_addr_o);
    end
    checks++;
    if (hold_o !== 1'b0 || div_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got hold=%0b req=%0b exp 0", hold_o, div_req_o);
    end
  endtask

  task automatic run_div(input string nm, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res,
                         input int lat);
    int r0;
    int w0;
    r0 = n_req;
    w0 = n_wb;
    drive(op, a, b, rd);
    #1;
    checks++;
    if (hold_o !== 1'b1 || div_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept got hold=%0b req=%0b exp 1/0", nm, hold_o, div_req_o);
    end
    cyc();
    checks++;
    if (div_req_o !== 1'b1 || hold_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_issue got req=%0b hold=%0b exp 1/1", nm, div_req_o, hold_o);
    end
    checks++;
    if (div_data1_o !== a || div_data2_o !== b ||
        div_op_code_o !== op || div_reg_wr_addr_o !== rd) begin
      errors++;
      $display("FAIL %s_latch got a=%h b=%h op=%0d rd=%0d exp a=%h b=%h op=%0d rd=%0d",
               nm, div_data1_o, div_data2_o, div_op_code_o, div_reg_wr_addr_o, a, b, op, rd);
    end
    cyc();
    checks++;
    if (div_req_o !== 1'b0 || hold_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait got req=%0b hold=%0b exp 0/1", nm, div_req_o, hold_o);
    end
    repeat (lat) cyc();
    div_res_ready_i = 1'b1;
    div_res_i = res;
    cyc();
    div_res_ready_i = 1'b0;
    div_res_i = 32'd0;
    checks++;
    if (wb_we_o !== 1'b1 || wb_addr_o !== rd || wb_data_o !== res || hold_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_wb got we=%0b addr=%0d data=%h hold=%0b exp 1 %0d %h 0",
               nm, wb_we_o, wb_addr_o, wb_data_o, hold_o, rd, res);
    end
    ex_div_req_i = 1'b0;
    cyc();
    checks++;
    if (wb_we_o !== 1'b0 || (n_req - r0) != 1 || (n_wb - w0) != 1) begin
      errors++;
      $display("FAIL %s_once got we=%0b reqs=%0d wbs=%0d exp 0 1 1",
               nm, wb_we_o, n_req - r0, n_wb - w0);
    end
  endtask

  task automatic test_fast(input string nm, input logic [2:0] op,
                           input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] exp_res);
    int r0;
    r0 = n_req;
    drive(op, a, 32'd0, rd);
    #1;
    checks++;
    if (hold_o !== 1'b1 || div_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_accept got hold=%0b req=%0b exp 1/0", nm, hold_o, div_req_o);
    end
    cyc();
    checks++;
    if (wb_we_o !== 1'b1 || wb_addr_o !== rd || wb_data_o !== exp_res || hold_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_wb got we=%0b addr=%0d data=%h hold=%0b exp 1 %0d %h 0",
               nm, wb_we_o, wb_addr_o, wb_data_o, hold_o, rd, exp_res);
    end
    ex_div_req_i = 1'b0;
    cyc();
    checks++;
    if (wb_we_o !== 1'b0 || n_req != r0) begin
      errors++;
      $display("FAIL %s_noreq got we=%0b reqs=%0d exp 0 0", nm, wb_we_o, n_req - r0);
    end
  endtask

  task automatic test_wb_flush();
    drive(OP_DIVU, 32'd9, 32'd0, 5'd7);
    cyc();
    ex_div_req_i = 1'b0;
    flush_i = 1'b1;
    #1;
    checks++;
    if (wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_flush got we=%0b exp 0", wb_we_o);
    end
    cyc();
    flush_i = 1'b0;
  endtask

  task automatic test_rd0();
    int r0;
    int w0;
    r0 = n_req;
    w0 = n_wb;
    drive(OP_DIV, 32'd8, 32'd2, 5'd0);
    #1;
    checks++;
    if (hold_o !== 1'b0) begin
      errors++;
      $display("FAIL rd0_hold got %0b exp 0", hold_o);
    end
    repeat (3) cyc();
    checks++;
    if (hold_o !== 1'b0 || n_req != r0 || n_wb != w0) begin
      errors++;
      $display("FAIL rd0_none got hold=%0b reqs=%0d wbs=%0d exp 0 0 0",
               hold_o, n_req - r0, n_wb - w0);
    end
    ex_div_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_flush_drain();
    int w0;
    w0 = n_wb;
    drive(OP_DIV, 32'd20, 32'd3, 5'd9);
    cyc();
    cyc();
    cyc();
    ex_div_req_i = 1'b0;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    #1;
    checks++;
    if (hold_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle_hold got %0b exp 0", hold_o);
    end
    drive(OP_DIV, 32'd10, 32'd3, 5'd10);
    #1;
    checks++;
    if (hold_o !== 1'b1) begin
      errors++;
      $display("FAIL drain_hold got %0b exp 1", hold_o);
    end
    repeat (3) cyc();
    checks++;
    if (hold_o !== 1'b1 || div_req_o !== 1'b0 || n_wb != w0) begin
      errors++;
      $display("FAIL drain_wait got hold=%0b req=%0b wbs=%0d exp 1 0 0",
               hold_o, div_req_o, n_wb - w0);
    end
    div_res_ready_i = 1'b1;
    div_res_i = 32'd6;
    cyc();
    div_res_ready_i = 1'b0;
    div_res_i = 32'd0;
    checks++;
    if (wb_we_o !== 1'b0 || n_wb != w0) begin
      errors++;
      $display("FAIL drain_discard got we=%0b wbs=%0d exp 0 0", wb_we_o, n_wb - w0);
    end
    run_div("after_drain", OP_DIV, 32'd10, 32'd3, 5'd10, 32'd3, 2);
  endtask

  task automatic test_flush_ready();
    drive(OP_DIV, 32'd20, 32'd3, 5'd9);
    cyc();
    cyc();
    ex_div_req_i = 1'b0;
    flush_i = 1'b1;
    div_res_ready_i = 1'b1;
    div_res_i = 32'd6;
    cyc();
    flush_i = 1'b0;
    div_res_ready_i = 1'b0;
    div_res_i = 32'd0;
    drive(OP_REMU, 32'd42, 32'd0, 5'd12);
    cyc();
    checks++;
    if (wb_we_o !== 1'b1 || wb_addr_o !== 5'd12 || wb_data_o !== 32'd42) begin
      errors++;
      $display("FAIL flush_ready_idle got we=%0b addr=%0d data=%h exp 1 12 0000002a",
               wb_we_o, wb_addr_o, wb_data_o);
    end
    ex_div_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int h0;
    do_reset();
    h0 = n_hold;
    drive(OP_DIV, 32'd1, 32'd1, 5'd11);
    cyc();
    cyc();
    repeat (63) cyc();
    checks++;
    if (wb_we_o !== 1'b0 || hold_o !== 1'b1 || div_err_o !== 1'b0) begin
      errors++;
      $display("FAIL to_early got we=%0b hold=%0b err=%0b exp 0 1 0",
               wb_we_o, hold_o, div_err_o);
    end
    cyc();
    checks++;
    if (wb_we_o !== 1'b1 || wb_addr_o !== 5'd11 || wb_data_o !== 32'd0 ||
        div_err_o !== 1'b1 || hold_o !== 1'b0) begin
      errors++;
      $display("FAIL to_wb got we=%0b addr=%0d data=%h err=%0b hold=%0b exp 1 11 0 1 0",
               wb_we_o, wb_addr_o, wb_data_o, div_err_o, hold_o);
    end
    ex_div_req_i = 1'b0;
    cyc();
    checks++;
    if (div_stall_cnt_o !== 32'd66) begin
      errors++;
      $display("FAIL to_stall got %0d exp 66", div_stall_cnt_o);
    end
    checks++;
    if (div_stall_cnt_o !== 32'(n_hold - h0)) begin
      errors++;
      $display("FAIL to_stall_obs got %0d exp %0d", div_stall_cnt_o, n_hold - h0);
    end
    repeat (5) cyc();
    checks++;
    if (div_err_o !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky got %0b exp 1", div_err_o);
    end
    do_reset();
    checks++;
    if (div_err_o !== 1'b0 || div_stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL to_clear got err=%0b cnt=%0d exp 0 0", div_err_o, div_stall_cnt_o);
    end
  endtask

  initial begin
    test_reset();
    run_div("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 3);
    run_div("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 1);
    run_div("remu", OP_REMU, 32'd7, 32'd2, 5'd5, 32'h1, 0);
    test_fast("divu0", OP_DIVU, 32'd9, 5'd7, 32'hFFFF_FFFF);
    test_fast("rem0", OP_REM, 32'd5, 5'd8, 32'h5);
    test_wb_flush();
    test_rd0();
    test_flush_drain();
    test_flush_ready();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
